// File: rtl/sram_bank_arbiter.sv
// Per-bank ZBT SRAM scheduler: NTSC > starved LPF/PT > VGA > round-robin LPF/PT, one access per cycle.
// Grant is combinational; write data and read capture are aligned to the SRAM pipeline depth.
module sram_bank_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [3:0]          wr,
    input  logic [4*ADDR_W-1:0] addr,
    input  logic [4*DATA_W-1:0] wdata,
    output logic [3:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic [3:0]          rdata_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we_b,
    output logic                mem_cen_b,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wdata_oe,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic [1:0]        owner;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t           pipe [LATENCY+1];
    entry_t           push;
    logic [CNT_W-1:0] cnt_lpf;
    logic [CNT_W-1:0] cnt_pt;
    logic             rr;
    logic             boost_lpf;
    logic             boost_pt;
    logic [3:0]       grant;
    logic [1:0]       sel;

    always_comb begin
        grant     = 4'b0000;
        boost_lpf = req[2] && (cnt_lpf == LIMIT);
        boost_pt  = req[3] && (cnt_pt == LIMIT);
        if (req[0])                    grant = 4'b0001;
        else if (boost_lpf && boost_pt) grant = rr ? 4'b1000 : 4'b0100;
        else if (boost_lpf)            grant = 4'b0100;
        else if (boost_pt)             grant = 4'b1000;
        else if (req[1])               grant = 4'b0010;
        else if (req[2] && req[3])     grant = rr ? 4'b1000 : 4'b0100;
        else if (req[2])               grant = 4'b0100;
        else if (req[3])               grant = 4'b1000;
    end

    always_comb begin
        sel = 2'd0;
        case (grant)
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    always_comb begin
        push = '0;
        if (|grant) begin
            push.vld   = 1'b1;
            push.wr    = wr[sel];
            push.owner = sel;
            push.wdata = wdata[sel*DATA_W +: DATA_W];
        end
    end

    // Waiting cycles count only while asking and losing; saturate so the boost stays sticky.
    function automatic logic [CNT_W-1:0] next_cnt(input logic r, input logic g,
                                                 input logic [CNT_W-1:0] c);
        if (!r || g) return '0;
        if (c == LIMIT) return c;
        return c + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_lpf     <= '0;
            cnt_pt      <= '0;
            rr          <= 1'b0;
            mem_addr    <= '0;
            mem_we_b    <= 1'b1;
            rdata       <= '0;
            rdata_valid <= 4'b0000;
            for (int i = 0; i <= LATENCY; i++) pipe[i] <= '0;
        end else begin
            cnt_lpf <= next_cnt(req[2], grant[2], cnt_lpf);
            cnt_pt  <= next_cnt(req[3], grant[3], cnt_pt);
            if (grant[2] || grant[3]) rr <= ~rr;
            if (|grant) begin
                mem_addr <= addr[sel*ADDR_W +: ADDR_W];
                mem_we_b <= ~wr[sel];
            end else begin
                mem_we_b <= 1'b1;
            end
            pipe[0] <= push;
            for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
            rdata_valid <= 4'b0000;
            // The tail entry lines up with the SRAM data phase of its own address.
            if (pipe[LATENCY].vld && !pipe[LATENCY].wr) begin
                rdata                          <= mem_rdata;
                rdata_valid[pipe[LATENCY].owner] <= 1'b1;
            end
        end
    end

    assign done         = reset ? 4'b0000 : grant;
    assign mem_cen_b    = reset;
    assign mem_wdata_oe = pipe[LATENCY].vld && pipe[LATENCY].wr;
    assign mem_wdata    = mem_wdata_oe ? pipe[LATENCY].wdata : '0;
endmodule
